// File: rtl/mem_stage_if.sv
// Memory-side request/response bus of the MEM pipeline stage.
// master = pipeline stage, slave = memory.
interface mem_stage_if;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic [15:0] memRData;
    logic        memReady;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memRData, memReady
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memRData, memReady
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass through in one cycle; LW/SW go through IDLE->REQ->RESP.
// Optional MEM_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES cycles and pulses memErr.
// Handshake: memReq rises in REQ and is held, with address, write data and memWe frozen,
// until the cycle in which memReady=1 completes the transfer; memReq is never high in IDLE or RESP.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    input  logic [15:0] instr,
    input  logic [15:0] aluResult,
    input  logic [15:0] storeData,
    input  logic [2:0]  flagsIn,
    input  logic        flush,
    output logic        stall,
    output logic        outValid,
    output logic [15:0] outInstr,
    output logic [15:0] outResult,
    output logic [2:0]  outFlags,
    output logic        memErr,
    output logic [1:0]  state_dbg,
    mem_stage_if.master mem
);
    // Opcode encodings shared with the core's instruction decoder.
    localparam logic [3:0] OP_LW = 4'hA;
    localparam logic [3:0] OP_SW = 4'hB;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t state;
    logic   valid_q;
    logic   kill;
    logic   is_mem;
    logic   is_sw;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          mem_err_q;
    assign memErr = mem_err_q;
`else
    assign memErr = 1'b0;
`endif

    assign is_sw     = (instr[15:12] == OP_SW);
    assign is_mem    = (instr[15:12] == OP_LW) || is_sw;
    assign stall     = (state != IDLE);
    assign state_dbg = state;
    // A flush arriving during the RESP cycle still squashes the result being presented.
    assign outValid  = valid_q && !((state == RESP) && flush);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid_q      <= 1'b0;
            kill         <= 1'b0;
            outInstr     <= 16'h0000;
            outResult    <= 16'h0000;
            outFlags     <= 3'b000;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= 16'h0000;
            mem.memWData <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            cnt          <= '0;
            mem_err_q    <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            mem_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (inValid && !flush) begin
                        outInstr <= instr;
                        outFlags <= flagsIn;
                        if (is_mem) begin
                            mem.memReq   <= 1'b1;
                            mem.memWe    <= is_sw;
                            mem.memAddr  <= aluResult;
                            mem.memWData <= storeData;
                            kill         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                            cnt          <= '0;
`endif
                            state        <= REQ;
                        end else begin
                            outResult <= aluResult;
                            valid_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.memReady) begin
                        outResult  <= mem.memWe ? mem.memAddr : mem.memRData;
                        mem.memReq <= 1'b0;
                        valid_q    <= !(kill || flush);
                        state      <= RESP;
                    end else begin
                        // A flush cannot withdraw the request; remember it for RESP.
                        kill <= kill || flush;
`ifdef MEM_TIMEOUT_EN
                        if (cnt == CNT_LAST) begin
                            outResult  <= 16'h0000;
                            mem.memReq <= 1'b0;
                            valid_q    <= !(kill || flush);
                            mem_err_q  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, LW/SW handshakes, flush cases, timeout, reset.
module tb_mem_stage;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LW  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic [15:0] instr;
    logic [15:0] aluResult;
    logic [15:0] storeData;
    logic [2:0]  flagsIn;
    logic        flush;
    logic        stall;
    logic        outValid;
    logic [15:0] outInstr;
    logic [15:0] outResult;
    logic [2:0]  outFlags;
    logic        memErr;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    int stall_cnt;

    mem_stage_if bus ();

    mem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .instr     (instr),
        .aluResult (aluResult),
        .storeData (storeData),
        .flagsIn   (flagsIn),
        .flush     (flush),
        .stall     (stall),
        .outValid  (outValid),
        .outInstr  (outInstr),
        .outResult (outResult),
        .outFlags  (outFlags),
        .memErr    (memErr),
        .state_dbg (state_dbg),
        .mem       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sdata,
                         input logic [2:0] flags);
        inValid   = 1'b1;
        instr     = {op, 12'h045};
        aluResult = addr;
        storeData = sdata;
        flagsIn   = flags;
        step();
        inValid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inValid = 1'b0; instr = '0; aluResult = '0; storeData = '0;
        flagsIn = '0; flush = 1'b0; bus.memReady = 1'b0; bus.memRData = '0;
        step(); step();
        chk("rst_outValid", outValid, 0);
        chk("rst_memReq", bus.memReq, 0);
        chk("rst_memWe", bus.memWe, 0);
        chk("rst_stall", stall, 0);
        chk("rst_outResult", outResult, 16'h0000);
        chk("rst_outInstr", outInstr, 16'h0000);
        chk("rst_memAddr", bus.memAddr, 16'h0000);
        chk("rst_memWData", bus.memWData, 16'h0000);
        chk("rst_outFlags", outFlags, 0);
        chk("rst_memErr", memErr, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        step();

        // ALU pass-through: one-cycle latency, no bus activity
        issue(OP_ADD, 16'h1234, 16'h0000, 3'b010);
        chk("add_outValid", outValid, 1);
        chk("add_outResult", outResult, 16'h1234);
        chk("add_outFlags", outFlags, 3'b010);
        chk("add_outInstr", outInstr, 16'h1045);
        chk("add_memReq", bus.memReq, 0);
        chk("add_stall", stall, 0);
        step();
        chk("add_outValid_drop", outValid, 0);

        // LW with memReady arriving 3 cycles after memReq
        stall_cnt = 0;
        issue(OP_LW, 16'h0040, 16'h5555, 3'b001);
        for (int i = 0; i < 4; i++) begin
            chk("lw_memReq", bus.memReq, 1);
            chk("lw_memAddr", bus.memAddr, 16'h0040);
            chk("lw_memWe", bus.memWe, 0);
            chk("lw_outValid_req", outValid, 0);
            if (stall) stall_cnt++;
            if (i == 3) begin
                bus.memReady = 1'b1;
                bus.memRData = 16'hBEEF;
            end
            step();
        end
        bus.memReady = 1'b0;
        if (stall) stall_cnt++;
        chk("lw_outValid", outValid, 1);
        chk("lw_outResult", outResult, 16'hBEEF);
        chk("lw_outInstr", outInstr, 16'hA045);
        chk("lw_outFlags", outFlags, 3'b001);
        chk("lw_memReq_resp", bus.memReq, 0);
        step();
        if (stall) stall_cnt++;
        chk("lw_stall_cycles", 16'(stall_cnt), 16'd5);
        chk("lw_outValid_drop", outValid, 0);

        // SW with upstream operands changing while stalled
        issue(OP_SW, 16'h0010, 16'h00AA, 3'b100);
        storeData = 16'hFFFF;
        aluResult = 16'h9999;
        chk("sw_memWData", bus.memWData, 16'h00AA);
        chk("sw_memWe", bus.memWe, 1);
        chk("sw_memAddr", bus.memAddr, 16'h0010);
        step();
        chk("sw_memWData_hold", bus.memWData, 16'h00AA);
        chk("sw_memReq_hold", bus.memReq, 1);
        bus.memReady = 1'b1;
        step();
        bus.memReady = 1'b0;
        chk("sw_outValid", outValid, 1);
        chk("sw_outResult", outResult, 16'h0010);
        chk("sw_outFlags", outFlags, 3'b100);
        step();

        // Flush in the second REQ cycle: request completes, result squashed
        issue(OP_LW, 16'h0020, 16'h0000, 3'b000);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_memReq_kept", bus.memReq, 1);
        bus.memReady = 1'b1;
        bus.memRData = 16'h1111;
        step();
        bus.memReady = 1'b0;
        chk("fl_outValid", outValid, 0);
        chk("fl_stall_resp", stall, 1);
        step();
        issue(OP_ADD, 16'h0077, 16'h0000, 3'b001);
        chk("fl_next_outValid", outValid, 1);
        chk("fl_next_outResult", outResult, 16'h0077);
        step();

        // Flush in IDLE discards the incoming LW
        flush = 1'b1;
        issue(OP_LW, 16'h0060, 16'h0000, 3'b000);
        flush = 1'b0;
        chk("fi_memReq", bus.memReq, 0);
        chk("fi_stall", stall, 0);
        chk("fi_outValid", outValid, 0);
        step();

        // Flush during RESP squashes the presented result
        issue(OP_LW, 16'h0030, 16'h0000, 3'b000);
        bus.memReady = 1'b1;
        bus.memRData = 16'h2222;
        step();
        bus.memReady = 1'b0;
        flush = 1'b1;
        #1;
        chk("fr_outValid_flushed", outValid, 0);
        flush = 1'b0;
        #1;
        chk("fr_outValid_unflushed", outValid, 1);
        chk("fr_outResult", outResult, 16'h2222);
        step();

        // Unanswered request: timeout build aborts after 15 REQ cycles, default build waits
        issue(OP_LW, 16'h0050, 16'h0000, 3'b000);
        for (int i = 0; i < 15; i++) begin
            chk("to_memReq_wait", bus.memReq, 1);
            chk("to_memErr_wait", memErr, 0);
            step();
        end
`ifdef MEM_TIMEOUT_EN
        chk("to_memReq_drop", bus.memReq, 0);
        chk("to_memErr", memErr, 1);
        chk("to_outValid", outValid, 1);
        chk("to_outResult", outResult, 16'h0000);
        step();
        chk("to_memErr_pulse", memErr, 0);
        chk("to_stall_idle", stall, 0);
`else
        for (int i = 0; i < 5; i++) begin
            chk("nt_memReq_held", bus.memReq, 1);
            step();
        end
        bus.memReady = 1'b1;
        bus.memRData = 16'h3333;
        step();
        bus.memReady = 1'b0;
        chk("nt_outValid", outValid, 1);
        chk("nt_outResult", outResult, 16'h3333);
        chk("nt_memErr", memErr, 0);
        step();
`endif

        // Reset asserted for one cycle while in REQ
        issue(OP_LW, 16'h0070, 16'h0000, 3'b000);
        chk("rr_memReq_pre", bus.memReq, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rr_memReq", bus.memReq, 0);
        chk("rr_outValid", outValid, 0);
        chk("rr_stall", stall, 0);
        chk("rr_state", state_dbg, 0);
        chk("rr_memErr", memErr, 0);
        issue(OP_ADD, 16'h00C3, 16'h0000, 3'b011);
        chk("rr_next_outValid", outValid, 1);
        chk("rr_next_outResult", outResult, 16'h00C3);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: the number of cycles to wait for memReady before aborting (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 inValid  input  1  EX result valid this cycle.
REQ-005 instr  input  16  instruction in EX; opcode is instr[15:12], compared against `LW/`SW from defines.v.
REQ-006 aluResult  input  16  EX result; used as the memory address for LW/SW.
REQ-007 storeData  input  16  second register operand; written to memory on SW.
REQ-008 flagsIn  input  3  EX flags {N,Z,V}.
REQ-009 flush  input  1  squash the current or incoming instruction.
REQ-010 stall  output  1  upstream holds its inputs; combinational, equals (state != IDLE).
REQ-011 memReq  output  1  memory request, held until memReady.
REQ-012 memWe  output  1  1 = write (SW), 0 = read (LW); valid while memReq is high.
REQ-013 memAddr  output  16  request address.
REQ-014 memWData  output  16  write data.
REQ-015 memRData  input  16  read data, valid when memReady is high.
REQ-016 memReady  input  1  memory completes the request this cycle.
REQ-017 outValid  output  1  the WB-stage outputs are valid.
REQ-018 outInstr  output  16  registered instruction.
REQ-019 outResult  output  16  load data for LW, else the registered aluResult.
REQ-020 outFlags  output  3  registered flagsIn.
REQ-021 memErr  output  1  one-cycle pulse when a transaction times out.

Function
REQ-022 States: IDLE, REQ, RESP; the block accepts input only when inValid=1 and state=IDLE.
REQ-023 Non-memory instruction accepted with flush=0: outValid=1 on the next cycle, with outInstr/outResult/outFlags taken from the inputs (1-cycle latency); otherwise outValid=0.
REQ-024 LW/SW accepted with flush=0: the address, write data, instruction, flags and we are latched, and the state moves IDLE->REQ.
REQ-025 In REQ: memReq=1 and memAddr/memWData/memWe are constant; the block stays in REQ while memReady=0.
REQ-026 In REQ with memReady=1: memRData is captured for LW, and the state moves REQ->RESP.
REQ-027 In RESP: outValid=1 for exactly one cycle with the latched instr and flags, and outResult=captured data (LW) or the latched address (SW); then RESP->IDLE.
REQ-028 Minimum LW/SW latency: accept in cycle n, memReq in n+1, outValid in n+2 if memReady is high in n+1; stall is high from n+1 through the RESP cycle.
REQ-029 memReq is never asserted in IDLE or RESP, so there are no back-to-back requests without an intervening IDLE cycle.
REQ-030 flush in IDLE: the incoming instruction is discarded (no request, outValid=0).
REQ-031 flush in REQ: the bus handshake still completes (the request is not withdrawn), and the kill is remembered so that RESP produces outValid=0.
REQ-032 flush in RESP, or flush in the same cycle as memReady: outValid=0 for that instruction.
REQ-033 Write data is never modified mid-request, even if upstream inputs change while stalled.

Reset
REQ-034 When rst_n=0 at a clock edge, the block forces state=IDLE, memReq=0, memWe=0, outValid=0, memErr=0, and outInstr/outResult/memAddr/memWData=16'h0000, outFlags=3'b000, and clears the kill flag and timeout counter.
REQ-035 Reset during REQ abandons the request immediately (memReq=0 on the next cycle) with no outValid and no memErr.

Configuration
REQ-036 With MEM_TIMEOUT_EN defined:
- a counter increments each REQ cycle.
- When it reaches TIMEOUT_CYCLES with memReady still 0: memReq drops, the state goes REQ->RESP, outResult=16'h0000, and memErr pulses for one cycle together with outValid (unless killed).
- The counter clears on entering REQ.
REQ-037 Without MEM_TIMEOUT_EN: no counter is built, REQ waits indefinitely, and memErr is tied to 0.

Verification
REQ-038 ADD (opcode not LW/SW) with aluResult=16'h1234, flagsIn=3'b010 -> next cycle outValid=1, outResult=16'h1234, outFlags=3'b010, memReq never high, stall=0.
REQ-039 LW with aluResult=16'h0040 and memReady high 3 cycles after memReq, memRData=16'hBEEF -> memAddr=16'h0040 and memWe=0 held for all REQ cycles; then outValid=1 with outResult=16'hBEEF; stall high 5 cycles.
REQ-040 SW with aluResult=16'h0010, storeData=16'h00AA, and upstream changing storeData while stalled -> memWData stays 16'h00AA, memWe=1, outResult=16'h0010.
REQ-041 LW with flush asserted in the second REQ cycle, then memReady -> request completes, outValid stays 0, next instruction accepted normally.
REQ-042 With MEM_TIMEOUT_EN and memReady held 0 -> memReq drops after 15 REQ cycles, memErr=1 and outValid=1 with outResult=16'h0000; without the macro, memReq stays high indefinitely.
REQ-043 rst_n=0 for one cycle during REQ -> next cycle memReq=0, outValid=0, stall=0, state IDLE.
